// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255 control-word / port C latch slice.
// Address map, control-word bit positions, FSM encoding and the captured write record.
package ppi_pkg;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CW_MODESET = 7;
  localparam int CW_PA_IN   = 4;
  localparam int CW_PCU_IN  = 3;
  localparam int CW_PB_IN   = 1;
  localparam int CW_PCL_IN  = 0;

  // All ports input, mode 0.
  localparam logic [7:0] DEF_RESET_CW = 8'h9B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] dat;
  } wr_req_t;

endpackage

// File: rtl/ppi_sync_bit.sv
// N-flop synchroniser for one asynchronous bus strobe; resets to RST_VAL.
// Latency STAGES clk; no backpressure.
module ppi_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/ppi_ctrl_unit.sv
// 8255 control-word and port C latch: captures CPU writes, decodes mode-set / BSR words.
// Update visible SYNC_STAGES+1 clk after the wr_n rising pin edge; one write in flight, accepted from IDLE only.
module ppi_ctrl_unit
  import ppi_pkg::*;
#(
  parameter logic [7:0] RESET_CW    = DEF_RESET_CW,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [1:0] addr,
  input  logic [7:0] d_in,
  output logic [7:0] ctrl_word,
  output logic [7:0] pc_latch,
  output logic       pa_in,
  output logic       pb_in,
  output logic       pcu_in,
  output logic       pcl_in,
  output logic       port_en,
  output logic       wr_done
);

  logic cs_s, wr_s, rd_s;

  ppi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s)
  );
  ppi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .d(wr_n), .q(wr_s)
  );
  ppi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .d(rd_n), .q(rd_s)
  );

  ctrl_state_e state;
  wr_req_t     req;
  logic        wr_start;

  assign wr_start = !cs_s && !wr_s && rd_s;

  // Updates land on the CAPTURE->COMMIT edge, so wr_done and the port_en
  // gap line up with the cycle in which the new values first appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req       <= '0;
      ctrl_word <= RESET_CW;
      pc_latch  <= '0;
      port_en   <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      port_en <= 1'b1;
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_start) begin
            state <= ST_CAPTURE;
            req   <= '{addr: addr, dat: d_in};
          end
        end
        ST_CAPTURE: begin
          req <= '{addr: addr, dat: d_in};
          if (!rd_s) begin
            state <= ST_IDLE;
          end else if (wr_s) begin
            state   <= ST_COMMIT;
            wr_done <= 1'b1;
            case (req.addr)
              ADDR_CTRL: begin
                if (req.dat[CW_MODESET]) begin
                  ctrl_word <= req.dat;
                  pc_latch  <= '0;
                  port_en   <= 1'b0;
                end else begin
                  pc_latch[req.dat[3:1]] <= req.dat[0];
                end
              end
              ADDR_PC: pc_latch <= req.dat;
              default: ;
            endcase
          end else if (cs_s) begin
            state <= ST_IDLE;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign pa_in  = ctrl_word[CW_PA_IN];
  assign pcu_in = ctrl_word[CW_PCU_IN];
  assign pb_in  = ctrl_word[CW_PB_IN];
  assign pcl_in = ctrl_word[CW_PCL_IN];

endmodule

// File: tb/tb_ppi_ctrl_unit.sv
// Bench for ppi_ctrl_unit: directed vector table, corner sequences, then random writes vs a model.
module tb_ppi_ctrl_unit;

  localparam int LAT = 3;  // SYNC_STAGES + 1 with default parameters

  logic       clk, rst_n, cs_n, wr_n, rd_n;
  logic [1:0] addr;
  logic [7:0] d_in, ctrl_word, pc_latch;
  logic       pa_in, pb_in, pcu_in, pcl_in, port_en, wr_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_cw, m_pc;

  ppi_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .d_in(d_in), .ctrl_word(ctrl_word), .pc_latch(pc_latch),
    .pa_in(pa_in), .pb_in(pb_in), .pcu_in(pcu_in), .pcl_in(pcl_in),
    .port_en(port_en), .wr_done(wr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp_cw;
    logic [7:0] exp_pc;
    int         exp_pe_low;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] cw, input logic [7:0] pc);
    check({tag, " ctrl_word"}, ctrl_word, cw);
    check({tag, " pc_latch"}, pc_latch, pc);
    check({tag, " dirs"}, {pa_in, pcu_in, pb_in, pcl_in}, {cw[4], cw[3], cw[1], cw[0]});
  endtask

  // Plain reading of the write rules, independent of how the RTL sequences it.
  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd3) begin
      if (d[7]) begin
        m_cw = d;
        m_pc = 8'h00;
      end else begin
        m_pc[d[3:1]] = d[0];
      end
    end else if (a == 2'd2) begin
      m_pc = d;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int low_cyc,
                          output int lat, output int nwd, output int npe);
    @(negedge clk);
    cs_n = 1'b0; addr = a; d_in = d; wr_n = 1'b0;
    repeat (low_cyc) @(negedge clk);
    wr_n = 1'b1;
    lat = -1; nwd = 0; npe = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wr_done) begin
        nwd++;
        if (lat < 0) lat = k;
      end
      if (!port_en) npe++;
    end
    cs_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat, nwd, npe;
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; addr = 2'd0; d_in = 8'h00;

    vecs[0] = '{2'd3, 8'h80, 8'h80, 8'h00, 1};
    vecs[1] = '{2'd3, 8'h0F, 8'h80, 8'h80, 0};
    vecs[2] = '{2'd3, 8'h0E, 8'h80, 8'h00, 0};
    vecs[3] = '{2'd2, 8'hA5, 8'h80, 8'hA5, 0};
    vecs[4] = '{2'd3, 8'h88, 8'h88, 8'h00, 1};
    vecs[5] = '{2'd0, 8'h5A, 8'h88, 8'h00, 0};
    vecs[6] = '{2'd3, 8'h07, 8'h88, 8'h08, 0};
    vecs[7] = '{2'd2, 8'h3C, 8'h88, 8'h3C, 0};
    vecs[8] = '{2'd3, 8'h9B, 8'h9B, 8'h00, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h9B, 8'h00);
    check("reset port_en", port_en, 1'b0);
    check("reset wr_done", wr_done, 1'b0);
    rst_n = 1'b1;
    #1 check("port_en before first edge", port_en, 1'b0);
    @(negedge clk);
    check("port_en after first edge", port_en, 1'b1);

    // Directed table
    foreach (vecs[i]) begin
      do_write(vecs[i].a, vecs[i].d, 3, lat, nwd, npe);
      check($sformatf("vec%0d latency", i), lat, LAT);
      check($sformatf("vec%0d wr_done pulses", i), nwd, 1);
      check($sformatf("vec%0d port_en low cycles", i), npe, vecs[i].exp_pe_low);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_cw, vecs[i].exp_pc);
    end
    m_cw = 8'h9B; m_pc = 8'h00;

    // Read strobe during a write: cycle aborts, nothing commits
    do_write(2'd2, 8'h5C, 2, lat, nwd, npe);
    model_write(2'd2, 8'h5C);
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd3; d_in = 8'h80; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    rd_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    nwd = 0; npe = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_done) nwd++;
      if (!port_en) npe++;
    end
    check("contention wr_done", nwd, 0);
    check("contention port_en low", npe, 0);
    check_outs("contention", m_cw, m_pc);

    // Reset while a mode-set write is captured
    @(negedge clk);
    cs_n = 1'b0; addr = 2'd3; d_in = 8'h80; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs("reset in capture", 8'h9B, 8'h00);
    check("reset in capture port_en", port_en, 1'b0);
    check("reset in capture wr_done", wr_done, 1'b0);
    @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    nwd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_done) nwd++;
    end
    check("post-reset wr_done", nwd, 0);
    check("post-reset port_en", port_en, 1'b1);
    check_outs("post-reset", 8'h9B, 8'h00);
    m_cw = 8'h9B; m_pc = 8'h00;

    // Random writes against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] ra;
      logic [7:0] rd;
      int         low;
      ra  = 2'($urandom_range(0, 3));
      rd  = 8'($urandom);
      low = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) ra = 2'd3;
      do_write(ra, rd, low, lat, nwd, npe);
      model_write(ra, rd);
      check($sformatf("rnd%0d latency", n), lat, LAT);
      check($sformatf("rnd%0d wr_done pulses", n), nwd, 1);
      check($sformatf("rnd%0d port_en low", n), npe, (ra == 2'd3 && rd[7]) ? 1 : 0);
      check_outs($sformatf("rnd%0d", n), m_cw, m_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
